// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers.
package pipe_pkg;

    // Stage occupancy states; 2'd3 is illegal and recovers to ST_EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_RESET = 32'hFFFF_FFFC;

    // Number of items held for a given state.
    function automatic logic [1:0] state_occupancy(input pipe_state_e state);
        logic [1:0] occ;
        occ = 2'd0;
        case (state)
            ST_BUSY: occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Environment side: feeds upstream data and downstream ready.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Stage register side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_data_cell.sv
// WIDTH-bit storage cell with load enable and async active-low reset.
module pipe_data_cell
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] r_data;

    // Capture i_value when loaded; reset value applies immediately.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            r_data <= RESET_VALUE;
        end else if (i_load) begin
            r_data <= i_value;
        end
    end

    assign o_data = r_data;
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a 2-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE  = WIDTH'(PC_RESET),
    parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(MIPS_NOP)
) (
    input  logic                   clock,
    input  logic                   reset_0,
    input  logic                   flush,
    pipe_stage_reg_if.slave        bus,
    output logic [1:0]             occupancy
);
    pipe_state_e      r_state;
    pipe_state_e      w_state_next;
    logic             r_in_ready;
    logic             w_out_valid;
    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_main_load;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_main_value;
    logic [WIDTH-1:0] w_skid_value;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;

    assign w_out_valid = (r_state == ST_BUSY) || (r_state == ST_FULL);
    assign w_xfer_in   = bus.in_valid & r_in_ready;
    assign w_xfer_out  = w_out_valid & bus.out_ready;

    // Next state and data-cell load controls; flush overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_main_load  = 1'b0;
        w_main_value = bus.in_data;
        w_skid_load  = 1'b0;
        w_skid_value = bus.in_data;
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_main_load  = 1'b1;
            w_main_value = BUBBLE_VALUE;
            w_skid_load  = 1'b1;
            w_skid_value = BUBBLE_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_xfer_in) begin
                        w_main_load  = 1'b1;
                        w_state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_xfer_in && w_xfer_out) begin
                        w_main_load = 1'b1;
                    end else if (w_xfer_in) begin
                        w_skid_load  = 1'b1;
                        w_state_next = ST_FULL;
                    end else if (w_xfer_out) begin
                        w_main_load  = 1'b1;
                        w_main_value = BUBBLE_VALUE;
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_xfer_out) begin
                        w_main_load  = 1'b1;
                        w_main_value = w_skid_q;
                        w_state_next = ST_BUSY;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered from the next state so no comb ready path.
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_FULL);
        end
    end

    pipe_data_cell #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clock   (clock),
        .reset_0 (reset_0),
        .i_load  (w_main_load),
        .i_value (w_main_value),
        .o_data  (w_main_q)
    );

    pipe_data_cell #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clock   (clock),
        .reset_0 (reset_0),
        .i_load  (w_skid_load),
        .i_value (w_skid_value),
        .o_data  (w_skid_q)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_main_q;
    assign occupancy     = state_occupancy(r_state);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: FIFO model of accepted items vs DUT output.
module tb_pipe_stage_reg;
    localparam logic [31:0] RESET_VAL  = 32'hFFFF_FFFC;
    localparam logic [31:0] BUBBLE_VAL = 32'h0000_0000;

    logic        clk;
    logic        reset_0;
    logic        flush;
    logic [1:0]  occupancy;

    pipe_stage_reg_if #(.WIDTH(32)) bus ();

    pipe_stage_reg #(
        .WIDTH        (32),
        .RESET_VALUE  (RESET_VAL),
        .BUBBLE_VALUE (BUBBLE_VAL)
    ) dut (
        .clock     (clk),
        .reset_0   (reset_0),
        .flush     (flush),
        .bus       (bus.slave),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] idle_val = RESET_VAL;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: just after each falling edge, compare DUT against the model and
    // consume the head item if the next rising edge transfers it out.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("occupancy", 32'(occupancy), 32'(exp_q.size()));
                check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
                check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
                if (exp_q.size() != 0) begin
                    check("out_data", bus.out_data, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        idle_val = BUBBLE_VAL;
                    end
                end else begin
                    check("idle_data", bus.out_data, idle_val);
                end
            end
        end
    end

    // One stimulus cycle; the model is updated after the monitor has consumed.
    task automatic cycle(input logic v, input logic [31:0] d, input logic ordy,
                         input logic fl, output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        #2;
        acc = v && bus.in_ready && !fl;
        if (fl) begin
            exp_q.delete();
            idle_val = BUBBLE_VAL;
        end else if (acc) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_data"}, bus.out_data, RESET_VAL);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    endtask

    // Assert reset between clock edges and check it takes effect without an edge.
    task automatic do_reset_mid();
        @(posedge clk);
        #3;
        mon_en  = 1'b0;
        reset_0 = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        exp_q.delete();
        idle_val = RESET_VAL;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        reset_0       = 1'b1;
        mon_en        = 1'b1;
    endtask

    initial begin
        logic acc;
        int   tries;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        reset_0       = 1'b1;
        #1;
        reset_0 = 1'b0;
        #1;
        check_reset_outputs("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_0 = 1'b1;
        mon_en  = 1'b1;

        // Flush while empty turns the PC-reset value into a bubble.
        cycle(1'b0, 32'd0, 1'b0, 1'b1, acc);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, acc);
        check("flush_empty_data", bus.out_data, BUBBLE_VAL);

        // Streaming 1..4 at full rate.
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 32'(i), 1'b1, 1'b0, acc);
            check("stream_accept", 32'(acc), 32'd1);
        end
        repeat (3) cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Stall: 10 accepted, 11 lands in skid, 12 held upstream.
        cycle(1'b1, 32'd10, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'd11, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd12, 1'b0, 1'b0, acc);
        check("stall_occ", 32'(occupancy), 32'd2);
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_12_held", 32'(acc), 32'd0);
        tries = 0;
        do begin
            cycle(1'b1, 32'd12, 1'b1, 1'b0, acc);
            tries++;
        end while (!acc && tries < 20);
        check("stall_12_accepted", 32'(acc), 32'd1);
        repeat (4) cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);

        // Flush while full drops both held items and the offered 7.
        cycle(1'b1, 32'd20, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'd21, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'd7, 1'b0, 1'b1, acc);
        check("full_before_flush", 32'(occupancy), 32'd2);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("flush_full_valid", 32'(bus.out_valid), 32'd0);
        check("flush_full_data", bus.out_data, BUBBLE_VAL);
        check("flush_full_occ", 32'(occupancy), 32'd0);

        // Drain: a single item then bubble.
        cycle(1'b1, 32'd5, 1'b1, 1'b0, acc);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("drain_data", bus.out_data, 32'd5);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("drain_bubble", bus.out_data, BUBBLE_VAL);

        // Random valid/ready/flush traffic with a mid-run reset.
        for (int n = 0; n < 1000; n++) begin
            if (n == 500) do_reset_mid();
            cycle(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0,
                  ($urandom % 32) == 0, acc);
        end
        repeat (6) cycle(1'b0, 32'd0, 1'b1, 1'b0, acc);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
